// File: rtl/calc_pkg.sv
// Shared display/calculator constants and types.
// Used by the scan driver, display and calculator blocks.
package calc_pkg;
   localparam int NUM_DIGITS = 4;
   localparam int SEG_W      = 8;
   localparam int PWM_BITS   = 4;
   localparam int SLOT_BITS  = $clog2(NUM_DIGITS);

   typedef logic [SEG_W-1:0] seg_t;

   // digit[0] is the leftmost digit; sign is the minus indicator.
   typedef struct packed {
      logic                       sign;
      seg_t [NUM_DIGITS-1:0]      digit;
   } disp_t;

   function automatic logic [NUM_DIGITS-1:0] slot_onehot(input logic [SLOT_BITS-1:0] slot);
      return {{(NUM_DIGITS-1){1'b0}}, 1'b1} << slot;
   endfunction
endpackage

// File: rtl/tick_gen.sv
// PWM tick prescaler: one-cycle tick every PRESCALE clocks while enabled.
// Held at zero while disabled so the scan restarts from a known phase.
module tick_gen #(
   parameter int PRESCALE = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic tick
);
   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (!enable) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = enable && (cnt == LAST);
endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit 7-segment scanner with PWM brightness and
// frame-synchronous double buffering of the display data.
module seg_scan_driver
   import calc_pkg::*;
#(
   parameter int PRESCALE = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  load,
   input  logic [SEG_W-1:0]      digit1,
   input  logic [SEG_W-1:0]      digit2,
   input  logic [SEG_W-1:0]      digit3,
   input  logic [SEG_W-1:0]      digit4,
   input  logic                  sign,
   input  logic [PWM_BITS-1:0]   brightness,
   output logic [SEG_W-1:0]      seg,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  sign_led,
   output logic                  frame_done
);
   logic                 tick;
   logic [PWM_BITS-1:0]  pwm_cnt;
   logic [PWM_BITS-1:0]  bri_q;
   logic [SLOT_BITS-1:0] slot;
   disp_t                pend_q;
   disp_t                shadow;
   logic                 pend_flag;
   disp_t                load_data;
   logic                 slot_end;
   logic                 frame_end;
   logic                 lit;

   tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .tick   (tick)
   );

   assign load_data = {sign, digit4, digit3, digit2, digit1};
   assign slot_end  = tick && (pwm_cnt == '1);
   assign frame_end = slot_end && (slot == SLOT_BITS'(NUM_DIGITS - 1));
   // pwm_cnt == 0 is the dark dead-time tick between digits
   assign lit       = enable && (pwm_cnt != '0) && (pwm_cnt <= bri_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pwm_cnt <= '0;
         slot    <= '0;
         bri_q   <= '0;
      end else begin
         if (pwm_cnt == '0) begin
            bri_q <= brightness;
         end
         if (!enable) begin
            pwm_cnt <= '0;
            slot    <= '0;
         end else if (tick) begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (slot_end) begin
               slot <= slot + SLOT_BITS'(1);
            end
         end
      end
   end

   // Shadow only ever changes on the frame boundary; a load landing on
   // the boundary itself goes straight to shadow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_q    <= '0;
         pend_flag <= 1'b0;
         shadow    <= '0;
      end else begin
         if (load) begin
            pend_q <= load_data;
         end
         if (frame_end) begin
            pend_flag <= 1'b0;
            if (load) begin
               shadow <= load_data;
            end else if (pend_flag) begin
               shadow <= pend_q;
            end
         end else if (load) begin
            pend_flag <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg        <= '0;
         an         <= '0;
         sign_led   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_end;
         sign_led   <= lit && (slot == '0) && shadow.sign;
         if (lit) begin
            seg <= shadow.digit[slot];
            an  <= slot_onehot(slot);
         end else begin
            seg <= '0;
            an  <= '0;
         end
      end
   end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with PRESCALE=2 (slot = 32 clk, frame = 128 clk).
// Stimulus queues expected lit runs and frame_done gaps; a negedge monitor measures and compares.
module tb_seg_scan_driver;
   localparam int PRESCALE = 2;

   logic       clk = 1'b0;
   logic       rst, enable, load, sign;
   logic [7:0] d1, d2, d3, d4;
   logic [3:0] brightness;
   logic [7:0] seg;
   logic [3:0] an;
   logic       sign_led, frame_done;

   always #5 clk = ~clk;

   seg_scan_driver #(.PRESCALE(PRESCALE)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .load       (load),
      .digit1     (d1),
      .digit2     (d2),
      .digit3     (d3),
      .digit4     (d4),
      .sign       (sign),
      .brightness (brightness),
      .seg        (seg),
      .an         (an),
      .sign_led   (sign_led),
      .frame_done (frame_done)
   );

   // One lit run: contiguous samples with the same an/seg/sign_led.
   // dark = unlit samples before the run (-1: not checked).
   typedef struct {
      logic [3:0] an;
      logic [7:0] seg;
      logic       sign;
      int         dark;
      int         len;
   } run_t;

   run_t run_q[$];
   int   fd_q[$];
   int   total = 0;
   int   bad   = 0;
   int   ecnt  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic exp_run(input logic [3:0] a, input logic [7:0] s, input logic sg,
                          input int dk, input int ln);
      run_t r;
      r.an = a; r.seg = s; r.sign = sg; r.dark = dk; r.len = ln;
      run_q.push_back(r);
   endtask

   // digs[7:0] = digit1 ... digs[31:24] = digit4
   task automatic exp_frame(input logic [31:0] digs, input logic sg, input int dk0,
                            input int dk, input int ln);
      for (int i = 0; i < 4; i++)
         exp_run(4'(1 << i), digs[8*i +: 8], (i == 0) ? sg : 1'b0, (i == 0) ? dk0 : dk, ln);
   endtask

   task automatic set_data(input logic [31:0] digs, input logic sg);
      d1 = digs[7:0]; d2 = digs[15:8]; d3 = digs[23:16]; d4 = digs[31:24]; sign = sg;
   endtask

   task automatic adv(input int n);
      repeat (n) begin
         @(posedge clk);
         ecnt++;
      end
      #1;
   endtask

   task automatic adv_to(input int t);
      if (t > ecnt) adv(t - ecnt);
   endtask

   // ---------------- monitor ----------------
   bit         in_run   = 1'b0;
   logic [3:0] r_an;
   logic [7:0] r_seg;
   logic       r_sign;
   int         r_len    = 0;
   int         r_dark   = 0;
   int         dark_cnt = 0;
   int         fd_gap   = 0;
   int         fd_exp;

   task automatic close_run();
      run_t e;
      total++;
      if (run_q.size() == 0) begin
         bad++;
         $display("FAIL run_unexpected an=%b seg=%h sign=%b len=%0d", r_an, r_seg, r_sign, r_len);
      end else begin
         e = run_q.pop_front();
         if (r_an !== e.an || r_seg !== e.seg || r_sign !== e.sign || r_len != e.len ||
             (e.dark >= 0 && r_dark != e.dark)) begin
            bad++;
            $display("FAIL run got an=%b seg=%h sign=%b dark=%0d len=%0d exp an=%b seg=%h sign=%b dark=%0d len=%0d",
                     r_an, r_seg, r_sign, r_dark, r_len, e.an, e.seg, e.sign, e.dark, e.len);
         end
      end
   endtask

   always @(negedge clk) begin
      fd_gap++;
      if (frame_done === 1'b1) begin
         total++;
         if (fd_q.size() == 0) begin
            bad++;
            $display("FAIL frame_done_unexpected gap=%0d", fd_gap);
         end else begin
            fd_exp = fd_q.pop_front();
            if (fd_exp >= 0 && fd_gap != fd_exp) begin
               bad++;
               $display("FAIL frame_done_gap got=%0d exp=%0d", fd_gap, fd_exp);
            end
         end
         fd_gap = 0;
      end
      total++;
      if (an === 4'b0 && (seg !== 8'h00 || sign_led !== 1'b0)) begin
         bad++;
         $display("FAIL dark_leak seg=%h sign_led=%b exp seg=00 sign_led=0", seg, sign_led);
      end
      if (in_run && (an === 4'b0 || an !== r_an || seg !== r_seg || sign_led !== r_sign)) begin
         close_run();
         in_run   = 1'b0;
         dark_cnt = 0;
      end
      if (an !== 4'b0) begin
         if (!in_run) begin
            in_run = 1'b1;
            r_an   = an;
            r_seg  = seg;
            r_sign = sign_led;
            r_len  = 1;
            r_dark = dark_cnt;
         end else begin
            r_len++;
         end
      end else begin
         dark_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; enable = 1'b0; load = 1'b0; brightness = 4'd15;
      set_data(32'h0, 1'b0);
      #1 rst = 1'b0;
      #1;
      check("reset_seg", 32'(seg), 32'h0);
      check("reset_an", 32'(an), 32'h0);
      check("reset_sign_led", 32'(sign_led), 32'h0);
      check("reset_frame_done", 32'(frame_done), 32'h0);
      adv(3);
      rst = 1'b1;
      adv(2);

      // load while idle goes to pending, shown from frame 1
      set_data(32'h664F5B06, 1'b1);
      load = 1'b1; adv(1); load = 1'b0;
      check("pend_after_idle_load", 32'(dut.pend_flag), 32'h1);

      exp_frame(32'h00000000, 1'b0, -1, 2, 30);
      exp_frame(32'h664F5B06, 1'b1, 2, 2, 30);
      exp_run(4'b0001, 8'h06, 1'b0, 2, 30);
      exp_run(4'b0010, 8'h3F, 1'b0, 2, 30);
      exp_run(4'b0100, 8'h4F, 1'b0, 2, 30);
      exp_run(4'b1000, 8'h66, 1'b0, 2, 8);
      exp_frame(32'h664F3F06, 1'b0, 24, 24, 8);
      exp_run(4'b0001, 8'h7F, 1'b1, -1, 30);
      exp_run(4'b0010, 8'h77, 1'b0, 2, 30);
      exp_run(4'b0100, 8'h39, 1'b0, 2, 4);
      fd_q.push_back(-1);
      for (int i = 0; i < 4; i++) fd_q.push_back(128);

      adv(1);
      enable = 1'b1;
      ecnt = 0;

      adv_to(170);                       // frame 1, slot 1
      set_data(32'h664F3F06, 1'b0);
      load = 1'b1; adv_to(171); load = 1'b0;
      check("pend_mid_frame", 32'(dut.pend_flag), 32'h1);
      adv_to(257);
      check("pend_cleared_at_boundary", 32'(dut.pend_flag), 32'h0);
      adv_to(330); brightness = 4'd4;    // mid slot 2: takes effect from slot 3
      adv_to(500); brightness = 4'd0;    // frame 4 fully dark
      adv_to(620); brightness = 4'd15;
      adv_to(639);                       // boundary cycle of frame 4
      set_data(32'h5E39777F, 1'b1);
      load = 1'b1; adv_to(640); load = 1'b0;
      check("pend_boundary_load", 32'(dut.pend_flag), 32'h0);

      adv_to(710);                       // frame 5, slot 2
      enable = 1'b0;
      adv_to(711);
      @(negedge clk);
      check("disable_an", 32'(an), 32'h0);
      check("disable_seg", 32'(seg), 32'h0);
      adv(3);
      set_data(32'h08040201, 1'b0);
      load = 1'b1; adv(1); load = 1'b0;
      check("pend_load_while_disabled", 32'(dut.pend_flag), 32'h1);
      adv(5);

      exp_frame(32'h5E39777F, 1'b1, -1, 2, 30);
      exp_run(4'b0001, 8'h01, 1'b0, 2, 30);
      exp_run(4'b0010, 8'h02, 1'b0, 2, 30);
      exp_run(4'b0100, 8'h04, 1'b0, 2, 30);
      exp_run(4'b1000, 8'h08, 1'b0, 2, 5);
      fd_q.push_back(-1);
      enable = 1'b1;
      ecnt = 0;

      adv_to(228);                       // second frame, slot 3
      set_data(32'hFFFFFFFF, 1'b1);
      load = 1'b1; adv_to(229); load = 1'b0;
      check("pend_before_reset", 32'(dut.pend_flag), 32'h1);
      adv_to(232);
      #2 rst = 1'b0;
      #1;
      check("async_rst_seg", 32'(seg), 32'h0);
      check("async_rst_an", 32'(an), 32'h0);
      check("async_rst_sign_led", 32'(sign_led), 32'h0);
      check("async_rst_pend", 32'(dut.pend_flag), 32'h0);
      check("async_rst_shadow", 32'(dut.shadow), 32'h0);

      exp_frame(32'h00000000, 1'b0, -1, 2, 30);
      exp_frame(32'h00000000, 1'b0, 2, 2, 30);
      fd_q.push_back(-1);
      fd_q.push_back(128);
      adv(2);
      rst = 1'b1;
      ecnt = 0;
      adv_to(262);

      check("runs_outstanding", 32'(run_q.size()), 32'h0);
      check("frame_done_outstanding", 32'(fd_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter PRESCALE, default 1000, meaning clk cycles per PWM tick (minimum 2).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port enable, input, 1, scan enable.
REQ-005 SHALL have port load, input, 1, single-cycle strobe that captures the display data.
REQ-006 SHALL have ports digit1, digit2, digit3, digit4, input, 8 each, segment patterns in order DP,g..a, with digit1 leftmost.
REQ-007 SHALL have port sign, input, 1, minus indicator.
REQ-008 SHALL have port brightness, input, 4, duty level from 0 to 15.
REQ-009 SHALL have port seg, output, 8, active-high segment drive.
REQ-010 SHALL have port an, output, 4, active-high one-hot digit select, with an[0] selecting digit1.
REQ-011 SHALL have port sign_led, output, 1, minus LED drive.
REQ-012 SHALL have port frame_done, output, 1, single-cycle pulse at each frame boundary.

Function
REQ-013 SHALL run a prescaler that counts 0..PRESCALE-1 while enable=1 and asserts tick for one cycle at PRESCALE-1.
REQ-014 SHALL use a 4-bit PWM counter that advances on tick and wraps from 15 to 0; each wrap ends a digit slot.
REQ-015 SHALL use a 2-bit slot counter that advances on slot end, in order 0→1→2→3→0; slot n drives digit(n+1).
REQ-016 SHALL define a frame as 4 slots, i.e. 64 ticks, i.e. 64·PRESCALE cycles.
REQ-017 SHALL sample brightness into an internal register when the PWM counter is 0; a change of brightness mid-slot SHALL have no effect until the next slot.
REQ-018 SHALL treat a digit as lit when pwm_cnt != 0 and pwm_cnt <= sampled brightness, giving a duty of brightness/16.
REQ-019 SHALL keep the pwm_cnt=0 tick dark in every slot as ghosting dead-time.
REQ-020 SHALL drive an with the one-hot slot select and seg with that slot's shadow pattern while the digit is lit; otherwise seg=0 and an=0.
REQ-021 SHALL register seg, an and sign_led, so they change exactly one clk after the counter state changes.
REQ-022 SHALL copy the four digits and sign into pending registers and set the pending flag on load=1.
REQ-023 SHALL resolve back-to-back loads so that the last one wins.
REQ-024 SHALL treat the frame boundary as the cycle of tick with pwm_cnt=15 and slot=3.
REQ-025 SHALL, at the frame boundary, copy pending into shadow if the pending flag is set, clear the flag, and pulse frame_done for one cycle.
REQ-026 SHALL, when load coincides with the frame boundary, move the load data straight into shadow and leave the pending flag clear.
REQ-027 SHALL never change shadow contents outside a frame boundary, so no frame ever tears.
REQ-028 SHALL drive sign_led with shadow sign, gated by enable and by the same lit condition as the slot for digit1.
REQ-029 SHALL, when enable=0, hold the prescaler, PWM and slot counters at 0, force seg, an, sign_led and frame_done to 0, and still accept load into pending.
REQ-030 SHALL, on enable rising, start the scan at slot 0, pwm 0.
REQ-031 SHALL, with brightness=0, keep seg and an at 0 permanently while frame_done continues to pulse.

Reset
REQ-032 SHALL, with rst=0, immediately and asynchronously clear all counters, shadow, pending, the pending flag and the sampled brightness, and set seg, an, sign_led and frame_done to 0.
REQ-033 SHALL, on reset asserted mid-frame, discard any pending load.
REQ-034 SHALL, after rst deasserts, start the scan at slot 0, pwm 0, prescaler 0, on the first clk edge with enable=1.

Structure
REQ-035 SHALL take NUM_DIGITS=4, SEG_W=8 and PWM_BITS=4 from shared package calc_pkg, which is also used by the display and calculator blocks.
REQ-036 SHALL implement the prescaler as one sub-module, tick_gen, with ports clk, rst, enable and tick.
REQ-037 SHALL keep all slot, PWM and shadow logic in seg_scan_driver.

Verification (PRESCALE=2)
REQ-038 SHALL check: reset, then enable=1, brightness=15, load of digit1..4 = 0x06, 0x5B, 0x4F, 0x66 → an walks 0001, 0010, 0100, 1000, each lit 30 cycles after 2 dark cycles; seg matches the slot's digit; frame_done pulses every 128 cycles.
REQ-039 SHALL check: brightness=4 → an high for 8 of every 32 cycles per slot; brightness=0 → an=0 always.
REQ-040 SHALL check: load of new digit2=0x3F mid-frame at slot 1 → seg for slot 1 still shows 0x5B until the boundary, and shows 0x3F in the next frame.
REQ-041 SHALL check: load exactly on the boundary cycle → new data visible in slot 0 of the following frame, with the pending flag remaining 0.
REQ-042 SHALL check: enable dropped in slot 2 → seg and an are 0 on the next cycle; after re-enable, the scan resumes at slot 0 with an=0001 after the dead tick.
REQ-043 SHALL check: rst pulsed low in slot 3 with a load pending → outputs 0 asynchronously, shadow 0x00, and the pending data is never displayed.
